// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings and default latencies.
package mult_div_unit_pkg;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  localparam int MDU_MULT_CYCLES_DEF = 5;
  localparam int MDU_DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/mdu_arith.sv
// Combinational datapath: computes the 64-bit HI:LO commit value from latched operands.
module mdu_arith
  import mult_div_unit_pkg::*;
(
  input  mdu_op_e     op,
  input  logic        madd,
  input  logic        msub,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [63:0] hilo,
  output logic [63:0] result,
  output logic        div_zero
);

  logic [63:0]        sprod, uprod;
  logic               sdiv_ovf;
  logic [31:0]        udivisor, sdivisor;
  logic [31:0]        uq, ur;
  logic signed [31:0] sq, sr;

  // Low 64 bits of the sign-extended product equal the signed 64-bit product.
  assign sprod    = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign uprod    = {32'b0, a} * {32'b0, b};

  assign div_zero = (b == 32'b0);
  assign sdiv_ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  // Substitute a harmless divisor where the real one is zero or overflows.
  assign udivisor = div_zero ? 32'd1 : b;
  assign sdivisor = (div_zero || sdiv_ovf) ? 32'd1 : b;

  assign uq = a / udivisor;
  assign ur = a % udivisor;
  assign sq = $signed(a) / $signed(sdivisor);
  assign sr = $signed(a) % $signed(sdivisor);

  always_comb begin
    result = hilo;
    case (op)
      MDU_MULT: begin
        if (msub)      result = hilo - sprod;
        else if (madd) result = hilo + sprod;
        else           result = sprod;
      end
      MDU_MULTU: result = uprod;
      MDU_DIV: begin
        if (sdiv_ovf) result = {32'h0, 32'h8000_0000};
        else          result = {sr, sq};
      end
      MDU_DIVU:  result = {ur, uq};
      default:   result = hilo;
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO for the E stage.
// Optional macro MDU_MSUB_EN adds the msub port (HI:LO -= signed A*B).
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        START,
  input  logic [1:0]  MDU_OP,
  input  logic        madd,
`ifdef MDU_MSUB_EN
  input  logic        msub,
`endif
  input  logic        HiLo,
  input  logic        WRITE_ENABLED,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        BUSY,
  output logic [31:0] OUT
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);

  logic [31:0]   hi, lo, a_q, b_q;
  logic [CW-1:0] cnt;
  logic          busy;
  mdu_op_e       op_q;
  logic          madd_q, msub_q, msub_in;
  logic [63:0]   result;
  logic          div_zero;

`ifdef MDU_MSUB_EN
  assign msub_in = msub;
`else
  assign msub_in = 1'b0;
`endif

  mdu_arith u_arith (
    .op       (op_q),
    .madd     (madd_q),
    .msub     (msub_q),
    .a        (a_q),
    .b        (b_q),
    .hilo     ({hi, lo}),
    .result   (result),
    .div_zero (div_zero)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      hi     <= '0;
      lo     <= '0;
      busy   <= 1'b0;
      cnt    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= MDU_MULT;
      madd_q <= 1'b0;
      msub_q <= 1'b0;
    end else if (busy) begin
      // Start and mt* requests are dropped while an operation is in flight.
      cnt <= cnt - 1'b1;
      if (cnt == CW'(1)) begin
        busy <= 1'b0;
        if (!(div_zero && op_q[1])) {hi, lo} <= result;
      end
    end else if (START) begin
      a_q    <= A;
      b_q    <= B;
      op_q   <= mdu_op_e'(MDU_OP);
      madd_q <= madd;
      msub_q <= msub_in;
      cnt    <= MDU_OP[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      busy   <= 1'b1;
    end else if (WRITE_ENABLED) begin
      if (HiLo) hi <= A;
      else      lo <= A;
    end
  end

  assign BUSY = busy;
  assign OUT  = HiLo ? hi : lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset, START, madd, msub, HiLo, WRITE_ENABLED;
  logic [1:0]  MDU_OP;
  logic [31:0] A, B, OUT;
  logic        BUSY;
  int          passed = 0;
  int          total  = 0;
  int          n;

  mult_div_unit dut (
    .clk           (clk),
    .reset         (reset),
    .START         (START),
    .MDU_OP        (MDU_OP),
    .madd          (madd),
`ifdef MDU_MSUB_EN
    .msub          (msub),
`endif
    .HiLo          (HiLo),
    .WRITE_ENABLED (WRITE_ENABLED),
    .A             (A),
    .B             (B),
    .BUSY          (BUSY),
    .OUT           (OUT)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    HiLo = 1'b1; #1;
    chk({tag, "_hi"}, OUT, exp_hi);
    HiLo = 1'b0; #1;
    chk({tag, "_lo"}, OUT, exp_lo);
  endtask

  task automatic mt(input logic sel, input logic [31:0] v);
    WRITE_ENABLED = 1'b1; HiLo = sel; A = v;
    step();
    WRITE_ENABLED = 1'b0;
  endtask

  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic madd_v, input logic msub_v);
    START = 1'b1; MDU_OP = op; A = a; B = b; madd = madd_v; msub = msub_v;
    step();
    START = 1'b0; madd = 1'b0; msub = 1'b0;
    // Scramble operands to show they were latched.
    A = 32'hDEAD_BEEF; B = 32'h0; MDU_OP = 2'b11;
  endtask

  task automatic count_busy(output int cnt);
    cnt = 0;
    while (BUSY && cnt < 50) begin
      cnt++;
      step();
    end
  endtask

  initial begin
    reset = 1'b0; START = 1'b0; madd = 1'b0; msub = 1'b0; HiLo = 1'b0;
    WRITE_ENABLED = 1'b0; MDU_OP = 2'b00; A = '0; B = '0;
    step(); step();
    chk("reset_busy", {31'b0, BUSY}, 32'd0);
    chk("reset_out", OUT, 32'd0);
    reset = 1'b1;

    // mthi
    WRITE_ENABLED = 1'b1; HiLo = 1'b1; A = 32'h1234;
    step();
    WRITE_ENABLED = 1'b0;
    chk("mthi_busy", {31'b0, BUSY}, 32'd0);
    chk_hilo("mthi", 32'h1234, 32'h0);

    // mult -3 * 7
    start_op(2'b00, -32'sd3, 32'd7, 1'b0, 1'b0);
    count_busy(n);
    chk("mult_cycles", n, 32'd5);
    chk_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFEB);

    // multu same operands
    start_op(2'b01, -32'sd3, 32'd7, 1'b0, 1'b0);
    count_busy(n);
    chk("multu_cycles", n, 32'd5);
    chk_hilo("multu", 32'h6, 32'hFFFF_FFEB);

    // div -7 / 2
    start_op(2'b10, -32'sd7, 32'd2, 1'b0, 1'b0);
    count_busy(n);
    chk("div_cycles", n, 32'd10);
    chk_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    // div INT_MIN / -1
    start_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    count_busy(n);
    chk_hilo("div_ovf", 32'h0, 32'h8000_0000);

    // divu by zero leaves HI/LO alone
    mt(1'b1, 32'd5);
    mt(1'b0, 32'd9);
    start_op(2'b11, 32'd100, 32'd0, 1'b0, 1'b0);
    count_busy(n);
    chk("divz_cycles", n, 32'd10);
    chk_hilo("divz", 32'd5, 32'd9);

    // madd with a START and mtlo injected mid-operation
    mt(1'b1, 32'h0);
    mt(1'b0, 32'hFFFF_FFFF);
    start_op(2'b00, 32'd1, 32'd1, 1'b1, 1'b0);
    n = 0;
    while (BUSY && n < 50) begin
      n++;
      if (n == 3) begin
        START = 1'b1; MDU_OP = 2'b00; A = 32'd100; B = 32'd100;
        WRITE_ENABLED = 1'b1; HiLo = 1'b0;
      end
      step();
      START = 1'b0; WRITE_ENABLED = 1'b0;
    end
    chk("madd_cycles", n, 32'd5);
    chk_hilo("madd", 32'd1, 32'd0);
    step(); step(); step();
    chk("madd_no_restart", {31'b0, BUSY}, 32'd0);
    chk_hilo("madd_hold", 32'd1, 32'd0);

    // reset during div
    start_op(2'b10, 32'd100, 32'd7, 1'b0, 1'b0);
    step(); step();
    chk("abort_busy_before", {31'b0, BUSY}, 32'd1);
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("abort_busy", {31'b0, BUSY}, 32'd0);
    chk_hilo("abort", 32'd0, 32'd0);
    step(); step();
    chk("abort_stays_idle", {31'b0, BUSY}, 32'd0);
    start_op(2'b00, 32'd6, 32'd7, 1'b0, 1'b0);
    count_busy(n);
    chk("post_cycles", n, 32'd5);
    chk_hilo("post", 32'd0, 32'd42);

`ifdef MDU_MSUB_EN
    mt(1'b1, 32'h0);
    mt(1'b0, 32'h0);
    start_op(2'b00, 32'd2, 32'd3, 1'b1, 1'b1);
    count_busy(n);
    chk("msub_cycles", n, 32'd5);
    chk_hilo("msub", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multi-cycle multiply/divide responder for the pipelined MIPS core. Sits in the execute stage and owns the architectural HI/LO registers.
- Accepts START/MDU_OP/madd/HiLo/WRITE_ENABLED from the decode-stage controller via the E-stage pipeline registers.
- Returns BUSY to the hazard unit and the HI or LO value to the E-stage result mux (mfhi/mflo).

Parameters:
- MULT_CYCLES, 5, BUSY cycles for mult/multu/madd (>=1)
- DIV_CYCLES, 10, BUSY cycles for div/divu (>=1)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset; reset==0 at a rising edge clears all state
- START  in  1  one-cycle start pulse for the operation selected by MDU_OP
- MDU_OP  in  2  00 mult, 01 multu, 10 div, 11 divu
- madd  in  1  with START and MDU_OP=00: HI:LO += signed A*B
- HiLo  in  1  1 selects HI, 0 selects LO, for both OUT and writes
- WRITE_ENABLED  in  1  mthi/mtlo: write A into the register selected by HiLo
- A  in  32  operand rs (forwarded E-stage value)
- B  in  32  operand rt (forwarded E-stage value)
- BUSY  out  1  operation in progress
- OUT  out  32  HiLo ? HI : LO, combinational from the registers

Behaviour:
- Reset (reset==0 at edge): HI=0, LO=0, BUSY=0, counter=0. Any in-flight operation is aborted and its result discarded. OUT=0 the following cycle.
- Idle = BUSY==0.
- START sampled at edge T0 while idle:
  - latches A, B, MDU_OP and madd
  - loads counter with MULT_CYCLES (MDU_OP[1]=0) or DIV_CYCLES
  - BUSY=1 from T0+1
- While BUSY: counter decrements each edge. At the edge where counter==1:
  - result commits to HI/LO
  - BUSY falls; the new HI/LO is visible on OUT in the same cycle that BUSY=0
- Total occupancy: START cycle + N BUSY cycles. The hazard unit stalls D on (START_E | BUSY) with an mf*/mt*/md-op in D. The block does not rely on that.
- START while BUSY: ignored (no restart, no queueing).
- WRITE_ENABLED while BUSY: ignored.
- WRITE_ENABLED and START together while idle: WRITE_ENABLED is ignored; START wins.
- WRITE_ENABLED while idle: updates the selected register at that edge. OUT reflects it next cycle.
- Arithmetic:
  - mult: HI:LO = $signed(A)*$signed(B), 64-bit
  - multu: unsigned product
  - madd: 64-bit wrap-around add of the signed product to the HI:LO value current at commit
  - madd with MDU_OP!=00 is treated as plain MDU_OP
- div: LO = quotient, truncated toward zero; HI = remainder, with the sign of the dividend.
- div INT_MIN/-1: LO=32'h80000000, HI=0.
- divu: unsigned quotient and remainder.
- B==0 for div/divu: BUSY runs the full DIV_CYCLES, then HI/LO are left unchanged.
- MDU_OP/A/B changing during BUSY has no effect, because operands are latched.

Optional Feature:
- Macro: MDU_MSUB_EN.
- Defined:
  - adds input port msub (1 bit)
  - START with msub=1 and MDU_OP=00 gives HI:LO -= signed A*B at commit, with MULT_CYCLES latency
  - madd and msub both set: msub wins
- Undefined: port absent; behaviour exactly as above.

Decomposition:
- Shared header (head.v `define set):
  - MDU_OP encodings: MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU
  - default cycle counts
- One natural sub-module: mdu_arith. Purely combinational; from latched operands, op, and current HI:LO it produces the 64-bit commit value and a div-by-zero flag.
- Counter, BUSY, HI/LO registers and the write port stay in mult_div_unit.

Test Plan:
- reset=0 for 2 cycles, then mthi A=32'h1234, HiLo=1 -> BUSY=0 throughout; OUT=32'h1234 next cycle with HiLo=1; OUT=0 with HiLo=0.
- mult A=-3, B=7 -> BUSY high exactly 5 cycles; then LO=32'hFFFFFFEB, HI=32'hFFFFFFFF. multu on the same operands -> HI=32'h6, LO=32'hFFFFFFEB.
- div A=-7, B=2 -> BUSY 10 cycles; LO=32'hFFFFFFFD, HI=32'hFFFFFFFF. div A=32'h80000000, B=-1 -> LO=32'h80000000, HI=0.
- HI=5, LO=9, then divu B=0 -> BUSY 10 cycles; HI=5, LO=9 unchanged.
- madd with HI:LO=0:32'hFFFFFFFF, A=1, B=1 -> HI=1, LO=0. A second START 2 cycles into BUSY is ignored (BUSY stays 5 cycles total, one result). mtlo during BUSY has no effect.
- reset=0 at BUSY cycle 3 of a div -> next cycle BUSY=0, HI=LO=0; a subsequent START works normally. With MDU_MSUB_EN: msub A=2, B=3 from HI:LO=0 -> HI=32'hFFFFFFFF, LO=32'hFFFFFFFA.
